// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, through
// a single full-subtractor cell, with a start/busy/done handshake and registered results.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic d_bit;
  logic br_nx;

  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        w_d  = {d_bit, w_q[WIDTH-1:1]};
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        br_d = br_nx;
        if (cnt_q == LAST) begin
          // counter parks on its last value rather than wrapping
          diff_d  = {d_bit, w_q[WIDTH-1:1]};
          bout_d  = br_nx;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
